tilelink_sram: RTL

- Parametrised TileLink-UL slave SRAM; next generation of the single-cycle block RAM.
- Adds configurable depth, PutFullData support, error responses and a 2-entry response FIFO, so the D channel tolerates host backpressure.
- Sits on the pinwheel bus as instruction/data/boot memory.
- Address decode uses the usual mask/tag match.

---
 rtl/tilelink_sram_if.sv | 32 +++
 rtl/tilelink_sram.sv | 106 ++++++++++
 2 files changed

// File: rtl/tilelink_sram_if.sv
// TileLink-UL A/D channel bundle between a bus host and the SRAM slave.
// bus_tld.d_ready doubles as the slave's A-channel ready.
interface tilelink_sram_if;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic        d_ready;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;

    tilelink_a tick_tla;
    logic      tick_d_ready;
    tilelink_d bus_tld;

    modport master (output tick_tla, output tick_d_ready, input bus_tld);
    modport slave  (input tick_tla, input tick_d_ready, output bus_tld);
endinterface

// File: rtl/tilelink_sram.sv
// TileLink-UL SRAM slave (Get/PutFull/PutPartial); response one cycle after accept.
// Two-entry response FIFO absorbs D backpressure; A-ready drops only when it is full.
module tilelink_sram #(
    parameter logic [31:0] addr_mask  = 32'hF000_0000,
    parameter logic [31:0] addr_tag   = 32'h0000_0000,
    parameter int          depth_log2 = 10,
    parameter string       filename   = ""
) (
    input logic           clock,
    input logic           reset,
    tilelink_sram_if.slave tl
);
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    logic [31:0] mem [0:(1 << depth_log2) - 1];
    rsp_t        fifo [0:1];
    rsp_t        head;
    rsp_t        new_rsp;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic                  a_ready;
    logic                  hit;
    logic                  accept;
    logic                  deq;
    logic                  bad_op;
    logic                  misaligned;
    logic                  err;
    logic [depth_log2-1:0] index;
    logic [31:0]           wdata;
    logic [3:0]            byte_en;

    assign hit        = tl.tick_tla.a_valid && ((tl.tick_tla.a_address & addr_mask) == addr_tag);
    assign a_ready    = !reset && (count != 2'd2);
    assign accept     = hit && a_ready;
    assign deq        = (count != 2'd0) && tl.tick_d_ready;
    assign index      = tl.tick_tla.a_address[depth_log2+1:2];
    assign bad_op     = !(tl.tick_tla.a_opcode == 3'd0 || tl.tick_tla.a_opcode == 3'd1 ||
                          tl.tick_tla.a_opcode == 3'd4);
    assign misaligned = (tl.tick_tla.a_size == 3'd2) && (tl.tick_tla.a_address[1:0] != 2'd0);
    assign err        = bad_op || misaligned;

    // PutPartial data is lane-aligned by the byte offset; the mask is not shifted.
    assign wdata = tl.tick_tla.a_opcode[0] ? (tl.tick_tla.a_data << {tl.tick_tla.a_address[1:0], 3'b000})
                                           : tl.tick_tla.a_data;

    always_comb begin
        byte_en = 4'h0;
        if (accept && !err) begin
            if (tl.tick_tla.a_opcode == 3'd0)      byte_en = 4'hF;
            else if (tl.tick_tla.a_opcode == 3'd1) byte_en = tl.tick_tla.a_mask;
        end
    end

    always_comb begin
        new_rsp.opcode = (!err && tl.tick_tla.a_opcode == 3'd4) ? 3'd1 : 3'd0;
        new_rsp.size   = tl.tick_tla.a_size;
        new_rsp.source = tl.tick_tla.a_source;
        new_rsp.data   = mem[index];
        new_rsp.error  = err;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (accept) fifo[wr_ptr] <= new_rsp;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (deq)    rd_ptr <= ~rd_ptr;
            case ({accept, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = fifo[rd_ptr];

    always_comb begin
        tl.bus_tld.d_valid  = (count != 2'd0);
        tl.bus_tld.d_ready  = a_ready;
        tl.bus_tld.d_opcode = head.opcode;
        tl.bus_tld.d_param  = 2'd0;
        tl.bus_tld.d_size   = head.size;
        tl.bus_tld.d_source = head.source;
        tl.bus_tld.d_sink   = 1'b0;
        tl.bus_tld.d_data   = head.data;
        tl.bus_tld.d_error  = head.error;
    end
endmodule
